// File: rtl/fifo_push_arb_if.sv
// Write-side bundle between the two producers / FIFO status and the push arbiter.
interface fifo_push_arb_if #(
    parameter int WIDTH = 64
);
    logic             req0, req1;
    logic             lock0, lock1;
    logic [WIDTH-1:0] data0, data1;
    logic             ack0, ack1;
    logic             fifo_full;
    logic             fifo_pop;
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             owner;
    logic             busy;
    logic             err;

    modport master (
        output req0, req1, lock0, lock1, data0, data1, fifo_full, fifo_pop,
        input  ack0, ack1, push_valid, push_data, owner, busy, err
    );

    modport slave (
        input  req0, req1, lock0, lock1, data0, data1, fifo_full, fifo_pop,
        output ack0, ack1, push_valid, push_data, owner, busy, err
    );
endinterface

// File: rtl/fifo_push_arb.sv
// Two-producer round-robin push arbiter with locked bursts in front of a FIFO write port.
// Optional FIFO_PUSH_ARB_STATS_EN adds per-requester 16-bit grant counters.
module fifo_push_arb #(
    parameter int WIDTH     = 64,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FIFO_PUSH_ARB_STATS_EN
    output logic [15:0]         gnt_cnt0,
    output logic [15:0]         gnt_cnt1,
`endif
    fifo_push_arb_if.slave      bus
);
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic       owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       ack0, ack1;
    logic       win;
    logic       can_push;
    logic       owner_req, owner_lock;

    assign can_push   = ~bus.fifo_full | bus.fifo_pop;
    assign owner_req  = owner_q ? bus.req1  : bus.req0;
    assign owner_lock = owner_q ? bus.lock1 : bus.lock0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        win     = 1'b0;
        // Stall (or reset) freezes everything, including a dropped-owner check.
        if (!rst && can_push) begin
            case (state_q)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        win  = (bus.req0 & bus.req1) ? rr_q : bus.req1;
                        ack0 = ~win;
                        ack1 = win;
                        rr_d = ~win;
                        if (win ? bus.lock1 : bus.lock0) begin
                            state_d = BURST;
                            owner_d = win;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                BURST: begin
                    if (owner_req) begin
                        ack0 = ~owner_q;
                        ack1 = owner_q;
                        // The last word of the burst is still accepted on exit.
                        if (!owner_lock || cnt_q == CNT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef FIFO_PUSH_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= 16'd0;
            gnt_cnt1 <= 16'd0;
        end else begin
            if (ack0) gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (ack1) gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif

    assign bus.ack0       = ack0;
    assign bus.ack1       = ack1;
    assign bus.push_valid = ack0 | ack1;
    assign bus.push_data  = ack0 ? bus.data0 : (ack1 ? bus.data1 : '0);
    assign bus.owner      = owner_q;
    assign bus.busy       = (state_q == BURST);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed-vector bench for fifo_push_arb: round-robin, bursts, stalls, drop error, reset.
module tb_fifo_push_arb;
    localparam int WIDTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    fifo_push_arb_if #(.WIDTH(WIDTH)) bus ();

`ifdef FIFO_PUSH_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    fifo_push_arb #(.WIDTH(WIDTH), .BURST_MAX(4)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef FIFO_PUSH_ARB_STATS_EN
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later still.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        bus.data0 = 64'hA0; bus.data1 = 64'hB1;
        bus.fifo_full = 1'b0; bus.fifo_pop = 1'b0;

        // Reset for two cycles; acks must be gated while rst is high.
        step();
        settle();
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_pv", bus.push_valid, 0);
        chk("rst_pd", bus.push_data, 0);
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_owner", bus.owner, 0);
        rst = 1'b0;

        // 1: tie with no lock alternates 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_ack0", bus.ack0, (i % 2 == 0));
            chk("rr_ack1", bus.ack1, (i % 2 == 1));
            chk("rr_pd", bus.push_data, (i % 2 == 0) ? 64'hA0 : 64'hB1);
            step();
        end

        // 2: locked burst from 0 holds the port for four words, then 1 wins.
        bus.lock0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data0 = 64'hA + 64'(i);
            settle();
            chk("bu_ack0", bus.ack0, 1);
            chk("bu_ack1", bus.ack1, 0);
            chk("bu_pd", bus.push_data, 64'hA + 64'(i));
            chk("bu_busy", bus.busy, (i != 0));
            step();
        end
        bus.data0 = 64'hE;
        settle();
        chk("bu_end_busy", bus.busy, 0);
        chk("bu_end_ack1", bus.ack1, 1);
        chk("bu_end_ack0", bus.ack0, 0);
        chk("bu_end_pd", bus.push_data, 64'hB1);
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0;
        step();

        // 3: full stalls; full+pop accepts.
        bus.req0 = 1'b1; bus.data0 = 64'h33; bus.fifo_full = 1'b1;
        settle();
        chk("full_ack0", bus.ack0, 0);
        chk("full_pv", bus.push_valid, 0);
        chk("full_pd", bus.push_data, 0);
        bus.fifo_pop = 1'b1;
        settle();
        chk("pop_ack0", bus.ack0, 1);
        chk("pop_pv", bus.push_valid, 1);
        chk("pop_pd", bus.push_data, 64'h33);
        step();
        bus.req0 = 1'b0; bus.fifo_full = 1'b0; bus.fifo_pop = 1'b0;

        // 4: owner 1 drops req after two words.
        bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.data1 = 64'h11;
        settle();
        chk("drop_w1", bus.ack1, 1);
        step();
        bus.data1 = 64'h12;
        settle();
        chk("drop_busy", bus.busy, 1);
        chk("drop_owner", bus.owner, 1);
        chk("drop_w2", bus.ack1, 1);
        step();
        bus.req1 = 1'b0; bus.req0 = 1'b1;
        settle();
        chk("drop_ack1", bus.ack1, 0);
        chk("drop_ack0", bus.ack0, 0);
        chk("drop_err0", bus.err, 0);
        step();
        bus.req0 = 1'b0; bus.lock1 = 1'b0;
        chk("drop_err", bus.err, 1);
        chk("drop_idle", bus.busy, 0);
        step();
        chk("drop_err_clr", bus.err, 0);

        // 5: reset during a burst at cnt=2.
        bus.req0 = 1'b1; bus.lock0 = 1'b1;
        settle();
        chk("rb_ack0", bus.ack0, 1);
        step();
        chk("rb_busy1", bus.busy, 1);
        step();
        chk("rb_busy2", bus.busy, 1);
        rst = 1'b1;
        settle();
        chk("rb_rst_ack0", bus.ack0, 0);
        step();
        rst = 1'b0; bus.req1 = 1'b1; bus.lock0 = 1'b0;
        settle();
        chk("rb_busy", bus.busy, 0);
        chk("rb_err", bus.err, 0);
        chk("rb_ack0_tie", bus.ack0, 1);
        chk("rb_ack1_tie", bus.ack1, 0);
        step();
        bus.req0 = 1'b0; bus.req1 = 1'b0;

`ifdef FIFO_PUSH_ARB_STATS_EN
        // 6: gnt_cnt0 wraps after 0xFFFF+2 grants.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("st_rst0", gnt_cnt0, 0);
        chk("st_rst1", gnt_cnt1, 0);
        bus.req0 = 1'b1;
        repeat (65537) step();
        bus.req0 = 1'b0;
        step();
        chk("st_wrap0", gnt_cnt0, 1);
        chk("st_keep1", gnt_cnt1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
